// File: rtl/lfsr_stream.sv
// Fibonacci LFSR random-word source with valid/ready output stream.
// IDLE/RUN control FSM, multi-step advance, saturating advance counter and period-wrap pulse.
module lfsr_stream #(
    parameter int unsigned           WIDTH   = 8,
    parameter logic [WIDTH-1:0]      TAPS    = WIDTH'(8'h1D),
    parameter int unsigned           STEPS   = 1,
    parameter int unsigned           COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rs,
    input  logic               load,
    input  logic [WIDTH-1:0]   seed,
    input  logic               start,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   q,
    output logic [COUNT_W-1:0] count,
    output logic               wrap
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] seed_reg;
    logic [WIDTH-1:0] q_adv;
    logic             advance;

    // The ~|x term pulls the register out of the all-zero lockup state.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] x);
        logic fb;
        fb = (^(x & TAPS)) ^ (~|x);
        return {fb, x[WIDTH-1:1]};
    endfunction

    always_comb begin
        q_adv = q;
        for (int unsigned i = 0; i < STEPS; i++) begin
            q_adv = lfsr_step(q_adv);
        end
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load || start) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    assign out_valid = (state == RUN);
    assign advance   = out_valid & out_ready & ~load;

    always_ff @(posedge clk) begin
        if (rs) begin
            q        <= '0;
            seed_reg <= '0;
            count    <= '0;
            wrap     <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                q        <= seed;
                seed_reg <= seed;
                count    <= '0;
            end else if (advance) begin
                q    <= q_adv;
                wrap <= (q_adv == seed_reg);
                if (count != '1) begin
                    count <= count + COUNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_stream.sv
// Bench for lfsr_stream: directed scenarios plus randomized traffic against a behavioural model.
module tb_lfsr_stream;

    logic        clk;
    logic        rs;
    logic        load;
    logic [7:0]  seed;
    logic        start;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  q;
    logic [15:0] count;
    logic        wrap;
    logic        out_valid1;
    logic [7:0]  q1;
    logic [3:0]  count1;
    logic        wrap1;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model of the default-parameter instance.
    logic [7:0] m_q;
    logic [7:0] m_seed;
    int         m_count;
    bit         m_run;
    bit         m_wrap;

    lfsr_stream dut (
        .clk(clk), .rs(rs), .load(load), .seed(seed), .start(start),
        .out_ready(out_ready), .out_valid(out_valid), .q(q), .count(count), .wrap(wrap)
    );

    lfsr_stream #(.STEPS(2), .COUNT_W(4)) dut2 (
        .clk(clk), .rs(rs), .load(load), .seed(seed), .start(start),
        .out_ready(out_ready), .out_valid(out_valid1), .q(q1), .count(count1), .wrap(wrap1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] ref_step(input logic [7:0] x);
        logic [7:0] r;
        int ones;
        if (x == 8'h00) return 8'h80;
        ones = $countones(x & 8'h1D);
        r = x >> 1;
        r[7] = ones[0];
        return r;
    endfunction

    task automatic tick();
        logic [7:0] nq;
        if (rs) begin
            m_q = '0; m_seed = '0; m_count = 0; m_wrap = 0; m_run = 0;
        end else if (load) begin
            m_q = seed; m_seed = seed; m_count = 0; m_wrap = 0; m_run = 1;
        end else if (m_run && out_ready) begin
            nq = ref_step(m_q);
            m_wrap = (nq == m_seed);
            m_q = nq;
            if (m_count < 65535) m_count++;
        end else begin
            m_wrap = 0;
            if (start) m_run = 1;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rs = 1; load = 0; start = 0; out_ready = 0; seed = '0;
        tick();
        rs = 0;
    endtask

    task automatic test_reset();
        rs = 1; load = 1; start = 1; out_ready = 1; seed = 8'hA5;
        tick();
        rs = 0; load = 0; start = 0; out_ready = 0;
        n_cmp++; if (q !== 8'h00) begin n_bad++; $display("FAIL reset_q got %h want 00", q); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_cmp++; if (count !== 16'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap got %b want 0", wrap); end
    endtask

    task automatic test_load_sequence();
        logic [7:0] exp_q [6] = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h88};
        do_reset();
        load = 1; seed = 8'h01; out_ready = 1;
        tick();
        load = 0;
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (q !== exp_q[i]) begin n_bad++; $display("FAIL seq_q[%0d] got %h want %h", i, q, exp_q[i]); end
            n_cmp++; if (count !== 16'(i)) begin n_bad++; $display("FAIL seq_count[%0d] got %0d want %0d", i, count, i); end
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL seq_valid[%0d] got %b want 1", i, out_valid); end
            tick();
        end
    endtask

    task automatic test_start();
        do_reset();
        out_ready = 1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL start_idle_valid got %b want 0", out_valid); end
        n_cmp++; if (q !== 8'h00) begin n_bad++; $display("FAIL start_idle_q got %h want 00", q); end
        start = 1;
        tick();
        start = 0;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL start_run_valid got %b want 1", out_valid); end
        n_cmp++; if (q !== 8'h00) begin n_bad++; $display("FAIL start_run_q got %h want 00", q); end
        tick();
        n_cmp++; if (q !== 8'h80) begin n_bad++; $display("FAIL start_step1 got %h want 80", q); end
        tick();
        n_cmp++; if (q !== 8'h40) begin n_bad++; $display("FAIL start_step2 got %h want 40", q); end
    endtask

    task automatic test_wrap();
        int seen [256];
        int pulses;
        int dupes;
        for (int i = 0; i < 256; i++) seen[i] = 0;
        pulses = 0;
        do_reset();
        load = 1; seed = 8'h01; out_ready = 1;
        tick();
        load = 0;
        for (int k = 1; k <= 255; k++) begin
            tick();
            seen[q]++;
            if (wrap === 1'b1) pulses++;
            if (k < 255) begin
                n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL wrap_early[%0d] got %b want 0 (q=%h)", k, wrap, q); end
            end
        end
        n_cmp++; if (q !== 8'h01) begin n_bad++; $display("FAIL wrap_q got %h want 01", q); end
        n_cmp++; if (count !== 16'd255) begin n_bad++; $display("FAIL wrap_count got %0d want 255", count); end
        n_cmp++; if (wrap !== 1'b1) begin n_bad++; $display("FAIL wrap_pulse got %b want 1", wrap); end
        n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL wrap_pulses got %0d want 1", pulses); end
        dupes = 0;
        for (int v = 1; v < 256; v++) if (seen[v] != 1) dupes++;
        if (seen[0] != 0) dupes++;
        n_cmp++; if (dupes != 0) begin n_bad++; $display("FAIL wrap_coverage got %0d bad values want 0", dupes); end
        out_ready = 0;
        tick();
        n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL wrap_clear got %b want 0", wrap); end
    endtask

    task automatic test_hold();
        do_reset();
        load = 1; seed = 8'h01; out_ready = 1;
        tick();
        load = 0;
        tick();
        tick();
        n_cmp++; if (q !== 8'h40) begin n_bad++; $display("FAIL hold_pre got %h want 40", q); end
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (q !== 8'h40) begin n_bad++; $display("FAIL hold_q[%0d] got %h want 40", i, q); end
            n_cmp++; if (count !== 16'd2) begin n_bad++; $display("FAIL hold_count[%0d] got %0d want 2", i, count); end
            n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL hold_wrap[%0d] got %b want 0", i, wrap); end
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid[%0d] got %b want 1", i, out_valid); end
        end
        out_ready = 1;
        tick();
        n_cmp++; if (q !== 8'h20) begin n_bad++; $display("FAIL hold_resume got %h want 20", q); end
        n_cmp++; if (count !== 16'd3) begin n_bad++; $display("FAIL hold_resume_count got %0d want 3", count); end
    endtask

    task automatic test_load_priority();
        do_reset();
        load = 1; seed = 8'h01; out_ready = 1;
        tick();
        load = 0;
        repeat (5) tick();
        n_cmp++; if (q !== 8'h88) begin n_bad++; $display("FAIL prio_pre got %h want 88", q); end
        load = 1; seed = 8'h5A;
        tick();
        load = 0;
        n_cmp++; if (q !== 8'h5A) begin n_bad++; $display("FAIL prio_load_q got %h want 5a", q); end
        n_cmp++; if (count !== 16'd0) begin n_bad++; $display("FAIL prio_load_count got %0d want 0", count); end
        load = 1; seed = 8'h01;
        tick();
        load = 0;
        repeat (5) tick();
        rs = 1; load = 1; seed = 8'h5A;
        tick();
        rs = 0; load = 0;
        n_cmp++; if (q !== 8'h00) begin n_bad++; $display("FAIL prio_rs_q got %h want 00", q); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL prio_rs_valid got %b want 0", out_valid); end
        n_cmp++; if (count !== 16'd0) begin n_bad++; $display("FAIL prio_rs_count got %0d want 0", count); end
    endtask

    task automatic test_steps2_saturate();
        logic [7:0] m2;
        int c2;
        do_reset();
        load = 1; seed = 8'h01; out_ready = 1;
        tick();
        load = 0;
        m2 = 8'h01; c2 = 0;
        n_cmp++; if (q1 !== 8'h01) begin n_bad++; $display("FAIL s2_load got %h want 01", q1); end
        tick();
        n_cmp++; if (q1 !== 8'h40) begin n_bad++; $display("FAIL s2_first got %h want 40", q1); end
        m2 = ref_step(ref_step(m2)); c2 = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            m2 = ref_step(ref_step(m2));
            if (c2 < 15) c2++;
            n_cmp++; if (q1 !== m2) begin n_bad++; $display("FAIL s2_q[%0d] got %h want %h", i, q1, m2); end
            n_cmp++; if (count1 !== 4'(c2)) begin n_bad++; $display("FAIL s2_count[%0d] got %0d want %0d", i, count1, c2); end
        end
        n_cmp++; if (count1 !== 4'd15) begin n_bad++; $display("FAIL s2_saturated got %0d want 15", count1); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rs        = ($urandom_range(63) == 0);
            load      = ($urandom_range(15) == 0);
            start     = ($urandom_range(7) == 0);
            out_ready = ($urandom_range(3) != 0);
            seed      = 8'($urandom);
            tick();
            n_cmp++; if (q !== m_q) begin n_bad++; $display("FAIL rnd_q[%0d] got %h want %h", i, q, m_q); end
            n_cmp++; if (count !== 16'(m_count)) begin n_bad++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, count, m_count); end
            n_cmp++; if (out_valid !== m_run) begin n_bad++; $display("FAIL rnd_valid[%0d] got %b want %b", i, out_valid, m_run); end
            n_cmp++; if (wrap !== m_wrap) begin n_bad++; $display("FAIL rnd_wrap[%0d] got %b want %b", i, wrap, m_wrap); end
        end
        rs = 0; load = 0; start = 0; out_ready = 0;
    endtask

    initial begin
        rs = 1; load = 0; start = 0; out_ready = 0; seed = '0;
        m_q = '0; m_seed = '0; m_count = 0; m_run = 0; m_wrap = 0;
        test_reset();
        test_load_sequence();
        test_start();
        test_wrap();
        test_hold();
        test_load_priority();
        test_steps2_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
